// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage: PC, in-order req/gnt/rvalid memory reads, buffered
//               instruction FIFO with PC tags, redirect flush with discard count.
//               Optional macro FETCH_ILLEGAL_CHECK_EN adds o_Instr_Illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int unsigned          WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic                 o_IMem_Req,
    output logic [WORD_SIZE-1:0] o_IMem_Addr,
    input  logic                 i_IMem_Gnt,
    input  logic                 i_IMem_RValid,
    input  logic [WORD_SIZE-1:0] i_IMem_RData,
    input  logic                 i_Redirect,
    input  logic [WORD_SIZE-1:0] i_Redirect_PC,
    output logic                 o_Instr_Valid,
    output logic [WORD_SIZE-1:0] o_Instruction,
    output logic [WORD_SIZE-1:0] o_Instr_PC,
`ifdef FETCH_ILLEGAL_CHECK_EN
    output logic                 o_Instr_Illegal,
`endif
    input  logic                 i_Decode_Ready
);

    localparam int unsigned          c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int unsigned          c_cnt_w    = c_ptr_w + 1;
    localparam int unsigned          c_sum_w    = c_cnt_w + 1;
    localparam logic [c_cnt_w:0]     c_depth    = c_sum_w'(FIFO_DEPTH);
    localparam logic [WORD_SIZE-1:0] c_pc_step  = WORD_SIZE'(4);
    localparam logic [WORD_SIZE-1:0] c_low_mask = WORD_SIZE'(3);
    localparam logic [WORD_SIZE-1:0] c_reset_pc = RESET_PC & ~c_low_mask;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               r_state_q,  w_state_d;
    logic [WORD_SIZE-1:0] r_pc_q,     w_pc_d;
    logic [c_cnt_w-1:0]   r_out_q,    w_out_d;
    logic [c_cnt_w-1:0]   r_disc_q,   w_disc_d;
    logic [c_cnt_w-1:0]   r_cnt_q,    w_cnt_d;
    logic [c_ptr_w-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [c_ptr_w-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [c_ptr_w-1:0]   r_tag_rd_q, w_tag_rd_d;
    logic [c_ptr_w-1:0]   r_tag_wr_q, w_tag_wr_d;

    logic                 w_run;
    logic [c_cnt_w:0]     w_credit;
    logic                 w_req;
    logic                 w_fire;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_push;
    logic [WORD_SIZE-1:0] w_tag_head;
    logic [WORD_SIZE-1:0] w_redirect_pc;

    logic [WORD_SIZE-1:0] w_instr_arr [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] w_ipc_arr   [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] w_tag_arr   [FIFO_DEPTH];
`ifdef FETCH_ILLEGAL_CHECK_EN
    logic                 w_ill_arr   [FIFO_DEPTH];
`endif

    always_comb begin
        w_run         = (r_state_q != ST_BOOT);
        // Buffered plus in-flight words never exceed the FIFO, so a push cannot overflow.
        w_credit      = {1'b0, r_cnt_q} + {1'b0, r_out_q};
        w_req         = w_run && (w_credit < c_depth) && !i_Redirect;
        w_fire        = w_req && i_IMem_Gnt;
        w_pop         = (r_cnt_q != '0) && i_Decode_Ready;
        w_drop        = i_IMem_RValid && (i_Redirect || (r_disc_q != '0));
        w_push        = i_IMem_RValid && !w_drop;
        w_tag_head    = w_tag_arr[r_tag_rd_q];
        w_redirect_pc = i_Redirect_PC & ~c_low_mask;

        w_out_d    = r_out_q + c_cnt_w'(w_fire) - c_cnt_w'(i_IMem_RValid);
        w_tag_wr_d = w_fire        ? (r_tag_wr_q + c_ptr_w'(1)) : r_tag_wr_q;
        w_tag_rd_d = i_IMem_RValid ? (r_tag_rd_q + c_ptr_w'(1)) : r_tag_rd_q;

        w_pc_d     = r_pc_q;
        w_disc_d   = r_disc_q;
        w_cnt_d    = r_cnt_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;

        if (i_Redirect) begin
            // Every read still in flight after this edge belongs to the old stream.
            w_pc_d     = w_redirect_pc;
            w_disc_d   = w_out_d;
            w_cnt_d    = '0;
            w_rd_ptr_d = r_wr_ptr_q;
        end else begin
            if (w_fire) begin
                w_pc_d = r_pc_q + c_pc_step;
            end
            if (i_IMem_RValid && (r_disc_q != '0)) begin
                w_disc_d = r_disc_q - c_cnt_w'(1);
            end
            w_cnt_d = r_cnt_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(1);
            end
        end

        case (r_state_q)
            ST_BOOT: w_state_d = ST_RUN;
            default: w_state_d = (w_disc_d != '0) ? ST_FLUSH : ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q  <= ST_BOOT;
            r_pc_q     <= c_reset_pc;
            r_out_q    <= '0;
            r_disc_q   <= '0;
            r_cnt_q    <= '0;
            r_rd_ptr_q <= '0;
            r_wr_ptr_q <= '0;
            r_tag_rd_q <= '0;
            r_tag_wr_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_out_q    <= w_out_d;
            r_disc_q   <= w_disc_d;
            r_cnt_q    <= w_cnt_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_tag_rd_q <= w_tag_rd_d;
            r_tag_wr_q <= w_tag_wr_d;
        end
    end

    // Instruction entries and request PC tags share the same depth.
    for (genvar e = 0; e < FIFO_DEPTH; e++) begin : g_entry
        logic [WORD_SIZE-1:0] r_instr_q;
        logic [WORD_SIZE-1:0] r_ipc_q;
        logic [WORD_SIZE-1:0] r_tag_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_instr_q <= '0;
                r_ipc_q   <= '0;
                r_tag_q   <= '0;
            end else begin
                if (w_push && (r_wr_ptr_q == c_ptr_w'(e))) begin
                    r_instr_q <= i_IMem_RData;
                    r_ipc_q   <= w_tag_head;
                end
                if (w_fire && (r_tag_wr_q == c_ptr_w'(e))) begin
                    r_tag_q <= r_pc_q;
                end
            end
        end

        assign w_instr_arr[e] = r_instr_q;
        assign w_ipc_arr[e]   = r_ipc_q;
        assign w_tag_arr[e]   = r_tag_q;

`ifdef FETCH_ILLEGAL_CHECK_EN
        logic r_ill_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_ill_q <= 1'b0;
            end else if (w_push && (r_wr_ptr_q == c_ptr_w'(e))) begin
                r_ill_q <= (i_IMem_RData[1:0] != 2'b11);
            end
        end

        assign w_ill_arr[e] = r_ill_q;
`endif
    end

    assign o_IMem_Req    = w_req;
    assign o_IMem_Addr   = r_pc_q;
    assign o_Instr_Valid = (r_cnt_q != '0);
    assign o_Instruction = w_instr_arr[r_rd_ptr_q];
    assign o_Instr_PC    = w_ipc_arr[r_rd_ptr_q];
`ifdef FETCH_ILLEGAL_CHECK_EN
    assign o_Instr_Illegal = w_ill_arr[r_rd_ptr_q];
`endif

    a_rvalid_needs_outstanding : assert property (
        @(posedge i_clk) disable iff (!i_rst_n) i_IMem_RValid |-> (r_out_q != '0)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit with a queue-based
//               memory and a behavioural fetch model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_IMem_Req;
    logic [31:0] o_IMem_Addr;
    logic        i_IMem_Gnt = 1'b0;
    logic        i_IMem_RValid = 1'b0;
    logic [31:0] i_IMem_RData = '0;
    logic        i_Redirect = 1'b0;
    logic [31:0] i_Redirect_PC = '0;
    logic        o_Instr_Valid;
    logic [31:0] o_Instruction;
    logic [31:0] o_Instr_PC;
    logic        i_Decode_Ready = 1'b0;
`ifdef FETCH_ILLEGAL_CHECK_EN
    logic        o_Instr_Illegal;
`endif

    always #5 i_clk = ~i_clk;

    instr_fetch_unit #(
        .WORD_SIZE (32),
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .o_IMem_Req     (o_IMem_Req),
        .o_IMem_Addr    (o_IMem_Addr),
        .i_IMem_Gnt     (i_IMem_Gnt),
        .i_IMem_RValid  (i_IMem_RValid),
        .i_IMem_RData   (i_IMem_RData),
        .i_Redirect     (i_Redirect),
        .i_Redirect_PC  (i_Redirect_PC),
        .o_Instr_Valid  (o_Instr_Valid),
        .o_Instruction  (o_Instruction),
        .o_Instr_PC     (o_Instr_PC),
`ifdef FETCH_ILLEGAL_CHECK_EN
        .o_Instr_Illegal(o_Instr_Illegal),
`endif
        .i_Decode_Ready (i_Decode_Ready)
    );

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { int due; logic [31:0] addr; } mreq_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    bit rand_gnt = 1'b0;

    mreq_t       mem_q[$];
    ent_t        m_fifo[$];
    logic [31:0] m_tags[$];
    logic [31:0] m_pc;
    int          m_out;
    int          m_disc;
    bit          m_boot;

    logic [31:0] granted[$];
    logic [31:0] popped_pc[$];
    logic [31:0] popped_ins[$];
    bit          popped_ill[$];
    int          first_grant_cyc;
    int          first_valid_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0500: return 32'h0000_4501;
            32'h0000_0504: return 32'h0000_0013;
            default:       return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        granted.delete();
        popped_pc.delete();
        popped_ins.delete();
        popped_ill.delete();
        first_grant_cyc = -1;
        first_valid_cyc = -1;
    endtask

    // One clock: drive at the falling edge, compare at +1, update everything at the rising edge.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit          rv, m_req, m_valid, m_fire, d_fire, m_pop;
        logic [31:0] d_addr, rdata;
        ent_t        e;
        rv    = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rdata = rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        i_Redirect     = redir;
        i_Redirect_PC  = rpc;
        i_Decode_Ready = rdy;
        i_IMem_RValid  = rv;
        i_IMem_RData   = rdata;
        i_IMem_Gnt     = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
        #1;
        m_req   = !m_boot && ((m_fifo.size() + m_out) < DEPTH) && !redir;
        m_valid = (m_fifo.size() > 0);
        chk("req", o_IMem_Req, m_req);
        if (m_req) chk("addr", o_IMem_Addr, m_pc);
        chk("valid", o_Instr_Valid, m_valid);
        if (m_valid) begin
            chk("instr", o_Instruction, m_fifo[0].instr);
            chk("instr_pc", o_Instr_PC, m_fifo[0].pc);
`ifdef FETCH_ILLEGAL_CHECK_EN
            chk("illegal", o_Instr_Illegal, m_fifo[0].instr[1:0] != 2'b11);
`endif
        end
        d_fire = o_IMem_Req && i_IMem_Gnt;
        d_addr = o_IMem_Addr;
        m_fire = m_req && i_IMem_Gnt;
        m_pop  = m_valid && rdy;
        if (d_fire) begin
            granted.push_back(d_addr);
            if (first_grant_cyc < 0) first_grant_cyc = cyc;
        end
        if (o_Instr_Valid && rdy && !redir) begin
            popped_pc.push_back(o_Instr_PC);
            popped_ins.push_back(o_Instruction);
`ifdef FETCH_ILLEGAL_CHECK_EN
            popped_ill.push_back(o_Instr_Illegal);
`endif
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        @(posedge i_clk);
        if (rv) void'(mem_q.pop_front());
        if (d_fire) mem_q.push_back('{due: cyc + lat, addr: d_addr});
        if (m_fire) m_tags.push_back(m_pc);
        e.instr = rdata;
        e.pc    = 32'h0;
        if (rv && (m_tags.size() > 0)) e.pc = m_tags.pop_front();
        m_out = m_out + int'(m_fire) - int'(rv);
        if (redir) begin
            m_disc = m_out;
            m_fifo.delete();
            m_pc = rpc & ~32'h3;
        end else begin
            if (m_pop) void'(m_fifo.pop_front());
            if (rv) begin
                if (m_disc > 0) m_disc--;
                else m_fifo.push_back(e);
            end
            if (m_fire) m_pc = m_pc + 32'd4;
        end
        m_boot = 1'b0;
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n        = 1'b0;
        i_IMem_Gnt     = 1'b0;
        i_IMem_RValid  = 1'b0;
        i_Redirect     = 1'b0;
        i_Decode_Ready = 1'b0;
        #1;
        chk("rst_req", o_IMem_Req, 0);
        chk("rst_addr", o_IMem_Addr, 32'h0);
        chk("rst_valid", o_Instr_Valid, 0);
        chk("rst_instr", o_Instruction, 32'h0);
        chk("rst_pc", o_Instr_PC, 32'h0);
        mem_q.delete();
        m_fifo.delete();
        m_tags.delete();
        m_pc   = 32'h0;
        m_out  = 0;
        m_disc = 0;
        m_boot = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic run_until_pops(input int n, input int budget);
        int k = 0;
        while ((popped_pc.size() < n) && (k < budget)) begin
            cycle(1'b0, 32'h0, 1'b1);
            k++;
        end
        chk("pop_timeout", popped_pc.size() >= n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        @(negedge i_clk);
        do_reset();

        // Streaming with 1-cycle memory.
        clear_logs();
        lat = 1;
        repeat (16) cycle(1'b0, 32'h0, 1'b1);
        chk("t1_grant0", granted[0], 32'h0);
        chk("t1_grant1", granted[1], 32'h4);
        chk("t1_grant2", granted[2], 32'h8);
        chk("t1_first_instr", popped_ins[0], 32'h5A5A_0003);
        chk("t1_latency", first_valid_cyc - first_grant_cyc, 32'd2);

        // Back-pressure: FIFO fills, requests stop, address holds.
        repeat (10) cycle(1'b0, 32'h0, 1'b0);
        chk("t2_req_low", o_IMem_Req, 0);
        chk("t2_valid_full", o_Instr_Valid, 1);
        chk("t2_addr_hold", o_IMem_Addr, m_pc);
        repeat (12) cycle(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < popped_pc.size(); i++) chk("t12_seq_pc", popped_pc[i], 32'(4 * i));

        // Redirect with two reads in flight on a 3-cycle memory.
        lat = 3;
        k = 0;
        while ((m_out != 2) && (k < 20)) begin
            cycle(1'b0, 32'h0, 1'b1);
            k++;
        end
        chk("t3_two_outstanding", m_out, 2);
        cycle(1'b1, 32'h0000_0100, 1'b1);
        chk("t3_valid_after_redir", o_Instr_Valid, 0);
        clear_logs();
        run_until_pops(2, 30);
        chk("t3_first_pc", popped_pc[0], 32'h0000_0100);
        chk("t3_second_pc", popped_pc[1], 32'h0000_0104);

        // Redirect in the same cycle as a grant and a response.
        lat = 1;
        k = 0;
        while (!((mem_q.size() > 0) && (mem_q[0].due <= cyc)) && (k < 10)) begin
            cycle(1'b0, 32'h0, 1'b1);
            k++;
        end
        chk("t4_rvalid_pending", (mem_q.size() > 0) && (mem_q[0].due <= cyc), 1);
        cycle(1'b1, 32'h0000_0200, 1'b1);
        clear_logs();
        run_until_pops(1, 20);
        chk("t4_first_pc", popped_pc[0], 32'h0000_0200);
        cycle(1'b1, 32'h0000_0300, 1'b1);
        cycle(1'b1, 32'h0000_0343, 1'b1);
        clear_logs();
        run_until_pops(2, 20);
        chk("t4_b2b_pc0", popped_pc[0], 32'h0000_0340);
        chk("t4_b2b_pc1", popped_pc[1], 32'h0000_0344);

        // Address wrap.
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        clear_logs();
        run_until_pops(2, 20);
        chk("t5_grant0", granted[0], 32'hFFFF_FFFC);
        chk("t5_grant1", granted[1], 32'h0000_0000);
        chk("t5_pc0", popped_pc[0], 32'hFFFF_FFFC);
        chk("t5_pc1", popped_pc[1], 32'h0000_0000);

        // Compressed vs. full-width encodings.
        cycle(1'b1, 32'h0000_0500, 1'b1);
        clear_logs();
        run_until_pops(2, 20);
        chk("t6_word0", popped_ins[0], 32'h0000_4501);
        chk("t6_word1", popped_ins[1], 32'h0000_0013);
`ifdef FETCH_ILLEGAL_CHECK_EN
        chk("t6_ill0", popped_ill[0], 1);
        chk("t6_ill1", popped_ill[1], 0);
`endif

        // Random grants, back-pressure and redirects.
        rand_gnt = 1'b1;
        lat = 2;
        repeat (300) cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0);
        lat = 1;
        repeat (150) cycle($urandom_range(0, 24) == 0, $urandom, $urandom_range(0, 2) != 0);

        // Reset in the middle of traffic.
        do_reset();
        rand_gnt = 1'b0;
        clear_logs();
        run_until_pops(2, 20);
        chk("t7_pc0", popped_pc[0], 32'h0);
        chk("t7_pc1", popped_pc[1], 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
